div_seq: RTL

Multi-cycle sequencer for the 32-bit integer divide resource used by `div.w`, `div.wu`, `mod.w` and `mod.wu`. It sits beside the EX stage:
- decode issues the operands and destination register through a valid/ready handshake;
- the block runs a radix-2 restoring divide over 32 iterations, fixes the signs, and holds the result until write-back accepts it;
- `busy` feeds the decode stall (`idu_nready_go`) so dependent instructions are held while a divide is in flight.

---
 rtl/div_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Multi-cycle sequencer for the 32-bit divide resource used by div.w/div.wu/mod.w/mod.wu.
// Radix-2 restoring divide on magnitudes, then a sign fix-up; the result is held until write-back takes it.
module div_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cancel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_waddr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_waddr,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_SIGN,
    S_DONE
  } state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [5:0]      cnt_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      waddr_q;

  logic [XLEN-1:0] src1_abs;
  logic [XLEN-1:0] src2_abs;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    src1_abs = (op_q[0] && src1_q[XLEN-1]) ? ('0 - src1_q) : src1_q;
    src2_abs = (op_q[0] && src2_q[XLEN-1]) ? ('0 - src2_q) : src2_q;
    // rem < divisor always holds, so 33 bits suffice for both the shift and the trial sign
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    trial    = rem_sh - {1'b0, dvsr_q};
    rem_d    = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_d    = {quo_q[XLEN-2:0], ~trial[XLEN]};
    quo_fix  = q_neg_q ? ('0 - quo_q) : quo_q;
    rem_fix  = r_neg_q ? ('0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else if (cancel) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q    <= in_op;
            src1_q  <= in_src1;
            src2_q  <= in_src2;
            waddr_q <= in_waddr;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          quo_q   <= src1_abs;
          dvsr_q  <= src2_abs;
          rem_q   <= '0;
          cnt_q   <= 6'd31;
          q_neg_q <= op_q[0] & (src1_q[XLEN-1] ^ src2_q[XLEN-1]);
          r_neg_q <= op_q[0] & src1_q[XLEN-1];
          if (src2_q == '0) begin
            result_q <= op_q[1] ? src1_q : '1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == '0) state_q <= S_SIGN;
        end
        S_SIGN: begin
          result_q <= op_q[1] ? rem_fix : quo_fix;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = result_q;
  assign out_waddr  = waddr_q;

endmodule
